// File: rtl/pipe_pkg.sv
// Shared encodings and defaults for the serial deserializer.
package pipe_pkg;

  localparam int W_DATA_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_fifo2.sv
// Two-entry FIFO. A push into a full FIFO is accepted when a pop happens
// in the same cycle; the entry leaving frees its slot at the same edge.
module pipe_fifo2 #(
  parameter int W = 33
) (
  input  logic         i_clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  logic [1:0][W-1:0] mem;
  logic              wp, rp;
  logic [1:0]        cnt;
  logic              pop_ok, push_ok;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rp];

  // Storage, pointers and occupancy; simultaneous push/pop keeps occupancy.
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      mem <= '0;
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wp] <= wdata;
        wp      <= ~wp;
      end
      if (pop_ok) rp <= ~rp;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/pipe_deser.sv
// Serial-to-parallel deserializer: MSB-first frames started by i_sof,
// optional trailing even-parity bit, results queued in a 2-entry FIFO.
module pipe_deser
  import pipe_pkg::*;
#(
  parameter int W_DATA    = W_DATA_DEF,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              resetn,
  input  logic              i_sen,
  input  logic              i_sbit,
  input  logic              i_sof,
  output logic [W_DATA-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_perr,
  output logic              o_overrun,
  output logic              o_abort,
  output logic              o_busy
);

  localparam int CW = $clog2(W_DATA + 1);

  state_t            state, state_n;
  logic [W_DATA-1:0] sreg, sreg_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              done, perr_n, abort_n;
  logic [W_DATA-1:0] word_n;
  logic              pop, full, empty;
  logic [W_DATA:0]   head;

  // Frame state register and shift register.
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic. Bits enter at the LSB and shift left, so the first
  // (sof) bit lands at W_DATA-1 once the frame is complete.
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    done    = 1'b0;
    perr_n  = 1'b0;
    word_n  = sreg;
    abort_n = 1'b0;
    if (i_sen) begin
      if (i_sof) begin
        abort_n = (state != IDLE);
        sreg_n  = {{(W_DATA-1){1'b0}}, i_sbit};
        cnt_n   = CW'(1);
        state_n = SHIFT;
      end else begin
        case (state)
          SHIFT: begin
            sreg_n = {sreg[W_DATA-2:0], i_sbit};
            cnt_n  = cnt + CW'(1);
            if (cnt == CW'(W_DATA - 1)) begin
              if (PARITY_EN) begin
                state_n = PARITY;
              end else begin
                state_n = IDLE;
                done    = 1'b1;
                word_n  = sreg_n;
              end
            end
          end
          PARITY: begin
            state_n = IDLE;
            done    = 1'b1;
            word_n  = sreg;
            perr_n  = (^sreg) ^ i_sbit;
          end
          default: state_n = state;
        endcase
      end
    end
  end

  assign pop = o_valid & i_ready;

  pipe_fifo2 #(.W(W_DATA + 1)) u_fifo (
    .i_clk  (i_clk),
    .resetn (resetn),
    .push   (done),
    .wdata  ({perr_n, word_n}),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );

  assign o_valid = ~empty;
  assign o_data  = head[W_DATA-1:0];
  assign o_perr  = head[W_DATA] & o_valid;
  assign o_busy  = (state != IDLE);

  // Event pulses, registered so they line up with the FIFO update.
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      o_overrun <= 1'b0;
      o_abort   <= 1'b0;
    end else begin
      o_overrun <= done & full & ~pop;
      o_abort   <= abort_n;
    end
  end

endmodule

// File: tb/tb_pipe_deser.sv
// Bench for pipe_deser (W_DATA=8, parity on): queue-level model plus
// directed frames with literal expectations.
module tb_pipe_deser;
  localparam int W = 8;

  logic         i_clk = 1'b0, resetn = 1'b0;
  logic         i_sen = 1'b0, i_sbit = 1'b0, i_sof = 1'b0, i_ready = 1'b1;
  logic [W-1:0] o_data;
  logic         o_valid, o_perr, o_overrun, o_abort, o_busy;
  int           checks = 0, failures = 0;

  pipe_deser #(.W_DATA(W), .PARITY_EN(1'b1)) dut (
    .i_clk(i_clk), .resetn(resetn), .i_sen(i_sen), .i_sbit(i_sbit),
    .i_sof(i_sof), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_perr(o_perr), .o_overrun(o_overrun), .o_abort(o_abort), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: frame = list of received bits; queue of {perr,data}, max 2.
  bit           bits[$];
  logic [W:0]   q[$];
  logic [W:0]   popped[$];
  bit           in_frame, m_ovr, m_abort;
  int           ovr_seen, abort_seen, m_ovr_cnt;

  initial forever begin
    @(posedge i_clk or negedge resetn);
    if (!resetn) begin
      bits.delete(); q.delete();
      in_frame = 0; m_ovr = 0; m_abort = 0;
    end else begin
      bit do_pop;
      do_pop = (q.size() > 0) && i_ready;
      m_ovr = 0; m_abort = 0;
      if (do_pop) begin popped.push_back(q[0]); void'(q.pop_front()); end
      if (i_sen) begin
        if (i_sof) begin
          m_abort = in_frame;
          bits.delete(); bits.push_back(i_sbit); in_frame = 1;
        end else if (in_frame) begin
          bits.push_back(i_sbit);
          if (bits.size() == W + 1) begin
            int word; int ones;
            word = 0; ones = 0;
            for (int i = 0; i < W; i++) word = word * 2 + int'(bits[i]);
            for (int i = 0; i <= W; i++) ones += int'(bits[i]);
            if (q.size() < 2) q.push_back({(ones % 2 == 1), W'(word)});
            else begin m_ovr = 1; m_ovr_cnt++; end
            bits.delete(); in_frame = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge i_clk);
    chk("valid", o_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("data", o_data, q[0][W-1:0]);
      chk("perr", o_perr, q[0][W]);
    end
    chk("overrun", o_overrun, m_ovr);
    chk("abort", o_abort, m_abort);
    chk("busy", o_busy, in_frame);
    if (o_overrun) ovr_seen++;
    if (o_abort) abort_seen++;
  end

  task automatic tick();
    @(negedge i_clk); #1;
  endtask

  task automatic strobe(input bit sof, input bit b, input bit gaps);
    i_sen = 1'b1; i_sof = sof; i_sbit = b;
    tick();
    i_sen = 1'b0; i_sof = 1'b0;
    if (gaps) repeat ($urandom_range(0, 3)) tick();
  endtask

  task automatic send(input logic [7:0] w, input bit par, input bit gaps);
    strobe(1'b1, w[7], gaps);
    for (int i = 6; i >= 0; i--) strobe(1'b0, w[i], gaps);
    strobe(1'b0, par, 1'b0);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_valid", o_valid, 0); chk("rst_data", o_data, 0);
    chk("rst_busy", o_busy, 0);   chk("rst_perr", o_perr, 0);
    resetn = 1'b1;
    tick();

    // A5 with good parity, then with bad parity
    send(8'hA5, 1'b0, 1'b0);
    chk("a5_valid", o_valid, 1); chk("a5_data", o_data, 8'hA5); chk("a5_perr", o_perr, 0);
    tick();
    send(8'hA5, 1'b1, 1'b0);
    chk("a5b_data", o_data, 8'hA5); chk("a5b_perr", o_perr, 1);
    repeat (2) tick();

    // overrun: three frames with consumer stalled
    i_ready = 1'b0; ovr_seen = 0; m_ovr_cnt = 0; popped.delete();
    send(8'h01, 1'b1, 1'b0);
    send(8'h02, 1'b1, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    tick();
    chk("ovr_dut", ovr_seen, 1); chk("ovr_model", m_ovr_cnt, 1);
    chk("stall_data", o_data, 8'h01);
    i_ready = 1'b1;
    tick();
    chk("pop2_data", o_data, 8'h02);
    tick();
    chk("drained", o_valid, 0);
    chk("pop_cnt", popped.size(), 2);
    if (popped.size() == 2) begin
      chk("pop0", popped[0][W-1:0], 8'h01); chk("pop1", popped[1][W-1:0], 8'h02);
    end

    // abort after 4 bits, then full 3C frame
    abort_seen = 0; popped.delete();
    strobe(1'b1, 1'b1, 1'b0);
    repeat (3) strobe(1'b0, 1'b1, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    chk("3c_data", o_data, 8'h3C);
    repeat (3) tick();
    chk("abort_cnt", abort_seen, 1);
    chk("3c_cnt", popped.size(), 1);
    if (popped.size() == 1) chk("3c_pop", popped[0][W-1:0], 8'h3C);

    // gaps between strobes
    popped.delete();
    send(8'h5A, 1'b0, 1'b1);
    chk("gap_data", o_data, 8'h5A); chk("gap_perr", o_perr, 0);
    tick();
    send(8'h96, 1'b1, 1'b1);
    chk("gap2_data", o_data, 8'h96); chk("gap2_perr", o_perr, 1);
    tick();
    send(8'h5A, 1'b0, 1'b0);
    chk("b2b_data", o_data, 8'h5A);
    repeat (2) tick();
    chk("gap_cnt", popped.size(), 3);

    // reset mid-frame with one word queued
    i_ready = 1'b0;
    send(8'h77, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0);
    repeat (3) strobe(1'b0, 1'b1, 1'b0);
    chk("pre_rst_busy", o_busy, 1);
    resetn = 1'b0;
    #1;
    chk("rst_mid_valid", o_valid, 0); chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_abort", o_abort, 0);
    repeat (2) tick();
    resetn = 1'b1; i_ready = 1'b1; popped.delete();
    tick();
    send(8'hC3, 1'b0, 1'b0);
    chk("c3_data", o_data, 8'hC3); chk("c3_perr", o_perr, 0);
    repeat (2) tick();
    chk("c3_cnt", popped.size(), 1);
    if (popped.size() == 1) chk("c3_pop", popped[0][W-1:0], 8'hC3);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_deser.md
PIPE_DESER -- requirements
Module: pipe_deser

Interface
REQ-001 Parameter W_DATA, default 32: payload word width in bits, minimum 2.
REQ-002 Parameter PARITY_EN, default 1: when 1, each frame carries one trailing even-parity bit.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 i_sen  input  1  serial bit strobe; i_sbit is sampled only when i_sen=1.
REQ-006 i_sbit  input  1  serial data bit, MSB first.
REQ-007 i_sof  input  1  start-of-frame; qualified by i_sen and marks the payload MSB.
REQ-008 o_data  output  W_DATA  head word of the output queue.
REQ-009 o_valid  output  1  o_data holds a valid word.
REQ-010 i_ready  input  1  consumer accepts the word when o_valid=1 and i_ready=1.
REQ-011 o_perr  output  1  parity-error flag for the head word; valid while o_valid=1.
REQ-012 o_overrun  output  1  one-cycle pulse when a completed word is dropped because the queue is full.
REQ-013 o_abort  output  1  one-cycle pulse when a partial frame is discarded by a new i_sof.
REQ-014 o_busy  output  1  high while the state machine is not IDLE.

Function
REQ-015 The state machine SHALL have exactly three states: IDLE, SHIFT and PARITY.
REQ-016 In IDLE, i_sen=1 with i_sof=1 SHALL load i_sbit as bit W_DATA-1, set the bit count to 1 and enter SHIFT; i_sen=1 with i_sof=0 SHALL be ignored.
REQ-017 In SHIFT, each i_sen=1 with i_sof=0 SHALL shift i_sbit in and increment the bit count; cycles with i_sen=0 SHALL hold all state.
REQ-018 When the bit count reaches W_DATA, the next state SHALL be PARITY if PARITY_EN=1, otherwise the word SHALL complete and the next state SHALL be IDLE.
REQ-019 In PARITY, i_sen=1 SHALL complete the word with perr = XOR(payload bits, i_sbit) and return to IDLE.
REQ-020 i_sen=1 with i_sof=1 in SHIFT or PARITY SHALL pulse o_abort, discard the partial word and restart as in REQ-016 in the same cycle.
REQ-021 A completed word and its perr SHALL be pushed into a 2-entry FIFO; o_valid SHALL rise on the cycle after the completing strobe (latency 1).
REQ-022 A push into a full FIFO SHALL drop the word and pulse o_overrun, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-023 A simultaneous push and pop on a non-empty FIFO SHALL keep the occupancy unchanged and preserve order.
REQ-024 o_data and o_perr SHALL remain stable while o_valid=1 and i_ready=0.
REQ-025 The bit counter SHALL be $clog2(W_DATA+1) bits wide and SHALL never wrap within a frame.

Reset
REQ-026 While resetn=0: state = IDLE, FIFO empty, and o_valid, o_perr, o_overrun, o_abort and o_busy all 0.
REQ-027 o_data SHALL reset to 0.
REQ-028 A reset in mid-frame SHALL discard the partial word and all queued words, with no o_abort pulse.

Structure
REQ-029 Package pipe_pkg SHALL hold the state encodings (IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2) and the default W_DATA.
REQ-030 Sub-module pipe_fifo2 SHALL implement the 2-entry FIFO with width parameter W_DATA+1 and push, pop, full and empty signals.

Verification
REQ-031 W_DATA=8, PARITY_EN=1: strobe i_sof and bits 1010_0101 then parity 0 -> o_valid=1 one cycle later with o_data=8'hA5 and o_perr=0.
REQ-032 Same frame with parity bit 1 -> o_data=8'hA5 and o_perr=1.
REQ-033 i_ready=0; send 3 frames 8'h01, 8'h02, 8'h03 -> 1 o_overrun pulse after the third; then popping yields 8'h01, then 8'h02.
REQ-034 i_sof after 4 bits, then a full frame of 8'h3C -> 1 o_abort pulse; the only word output is 8'h3C.
REQ-035 Gaps of 0 to 3 idle cycles between strobes -> identical output to back-to-back strobes, and o_busy=1 throughout the frame.
REQ-036 Assert resetn=0 mid-frame with 1 word queued -> o_valid=0 and o_busy=0 immediately; the next full frame is received correctly.
